// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcode values, opcode width and FSM encoding.
package alu_pkg;

   localparam int OP_W = 4;

   localparam logic [OP_W-1:0] OP_ADD = 4'b0000;
   localparam logic [OP_W-1:0] OP_SUB = 4'b0001;
   localparam logic [OP_W-1:0] OP_AND = 4'b0010;
   localparam logic [OP_W-1:0] OP_NOT = 4'b0011;
   localparam logic [OP_W-1:0] OP_OR  = 4'b0100;
   localparam logic [OP_W-1:0] OP_XOR = 4'b0101;
   localparam logic [OP_W-1:0] OP_SHL = 4'b0110;
   localparam logic [OP_W-1:0] OP_SHR = 4'b0111;
   localparam logic [OP_W-1:0] OP_SRA = 4'b1000;
   localparam logic [OP_W-1:0] OP_MUL = 4'b1001;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_BUSY = 2'b01,
      ST_DONE = 2'b10
   } state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, LSB first.
// Bit 0 is consumed on the start edge so done pulses WIDTH-1 cycles after start.
module alu_mul_iter #(
   parameter int WIDTH = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   localparam int CNT_W = $clog2(WIDTH) + 1;

   logic [2*WIDTH-1:0] mcand_reg;
   logic [WIDTH-1:0]   mplier_reg;
   logic [2*WIDTH-1:0] acc_reg;
   logic [CNT_W-1:0]   cnt_reg;
   logic               busy_reg;
   logic               done_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mcand_reg  <= '0;
         mplier_reg <= '0;
         acc_reg    <= '0;
         cnt_reg    <= '0;
         busy_reg   <= 1'b0;
         done_reg   <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         if (start) begin
            mcand_reg  <= {{WIDTH{1'b0}}, a} << 1;
            mplier_reg <= b >> 1;
            acc_reg    <= b[0] ? {{WIDTH{1'b0}}, a} : '0;
            cnt_reg    <= CNT_W'(1);
            busy_reg   <= 1'b1;
         end else if (busy_reg) begin
            if (mplier_reg[0])
               acc_reg <= acc_reg + mcand_reg;
            mcand_reg  <= mcand_reg << 1;
            mplier_reg <= mplier_reg >> 1;
            cnt_reg    <= cnt_reg + CNT_W'(1);
            // cnt_reg is the index of the bit being consumed this cycle
            if (cnt_reg == CNT_W'(WIDTH - 1)) begin
               busy_reg <= 1'b0;
               done_reg <= 1'b1;
            end
         end
      end
   end

   assign busy    = busy_reg;
   assign done    = done_reg;
   assign product = acc_reg;

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle logic/arith/shift ops, iterative multiply,
// registered result and status flags held until the consumer accepts them.
module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [OP_W-1:0]  op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             carry,
   output logic             overflow,
   output logic             negative,
   output logic             illegal
);

   localparam int SH_W = $clog2(WIDTH);

   state_t state_reg, state_next;

   logic [WIDTH-1:0]   result_reg;
   logic               zero_reg, carry_reg, overflow_reg, negative_reg, illegal_reg;

   logic               load_alu, load_mul, mul_start;
   logic               mul_busy, mul_done;
   logic [2*WIDTH-1:0] mul_product;

   logic [WIDTH-1:0]   res_c;
   logic               carry_c, ovf_c, illegal_c;
   logic [WIDTH:0]     sum_w, diff_w, shl_w, shr_w, sra_w;
   logic [SH_W-1:0]    shamt;

   alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
      .clk     (clk),
      .rst     (rst),
      .start   (mul_start),
      .a       (a),
      .b       (b),
      .busy    (mul_busy),
      .done    (mul_done),
      .product (mul_product)
   );

   // Extra bit on each shift captures the last bit shifted out (0 when shamt is 0)
   assign shamt  = b[SH_W-1:0];
   assign sum_w  = {1'b0, a} + {1'b0, b};
   assign diff_w = {1'b0, a} - {1'b0, b};
   assign shl_w  = {1'b0, a} << shamt;
   assign shr_w  = {a, 1'b0} >> shamt;
   assign sra_w  = $signed({a, 1'b0}) >>> shamt;

   always_comb begin
      res_c     = '0;
      carry_c   = 1'b0;
      ovf_c     = 1'b0;
      illegal_c = 1'b0;
      case (op)
         OP_ADD: begin
            res_c   = sum_w[WIDTH-1:0];
            carry_c = sum_w[WIDTH];
            ovf_c   = (a[WIDTH-1] == b[WIDTH-1]) && (sum_w[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            res_c   = diff_w[WIDTH-1:0];
            carry_c = diff_w[WIDTH];
            ovf_c   = (a[WIDTH-1] != b[WIDTH-1]) && (diff_w[WIDTH-1] != a[WIDTH-1]);
         end
         OP_AND: res_c = a & b;
         OP_NOT: res_c = ~a;
         OP_OR:  res_c = a | b;
         OP_XOR: res_c = a ^ b;
         OP_SHL: begin
            res_c   = shl_w[WIDTH-1:0];
            carry_c = shl_w[WIDTH];
         end
         OP_SHR: begin
            res_c   = shr_w[WIDTH:1];
            carry_c = shr_w[0];
         end
         OP_SRA: begin
            res_c   = sra_w[WIDTH:1];
            carry_c = sra_w[0];
         end
         OP_MUL: res_c = '0;
         default: illegal_c = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state_reg <= ST_IDLE;
      else
         state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      load_alu   = 1'b0;
      load_mul   = 1'b0;
      mul_start  = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               if (op == OP_MUL) begin
                  mul_start  = 1'b1;
                  state_next = ST_BUSY;
               end else begin
                  load_alu   = 1'b1;
                  state_next = ST_DONE;
               end
            end
         end
         ST_BUSY: begin
            if (mul_done) begin
               load_mul   = 1'b1;
               state_next = ST_DONE;
            end else if (!mul_busy) begin
               state_next = ST_IDLE;
            end
         end
         ST_DONE: begin
            out_valid = 1'b1;
            if (out_ready)
               state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         result_reg   <= '0;
         zero_reg     <= 1'b0;
         carry_reg    <= 1'b0;
         overflow_reg <= 1'b0;
         negative_reg <= 1'b0;
         illegal_reg  <= 1'b0;
      end else if (load_alu) begin
         result_reg   <= res_c;
         zero_reg     <= (res_c == '0);
         carry_reg    <= carry_c;
         overflow_reg <= ovf_c;
         negative_reg <= res_c[WIDTH-1];
         illegal_reg  <= illegal_c;
      end else if (load_mul) begin
         result_reg   <= mul_product[WIDTH-1:0];
         zero_reg     <= (mul_product[WIDTH-1:0] == '0);
         carry_reg    <= |mul_product[2*WIDTH-1:WIDTH];
         overflow_reg <= |mul_product[2*WIDTH-1:WIDTH];
         negative_reg <= mul_product[WIDTH-1];
         illegal_reg  <= 1'b0;
      end
   end

   assign result   = result_reg;
   assign zero     = zero_reg;
   assign carry    = carry_reg;
   assign overflow = overflow_reg;
   assign negative = negative_reg;
   assign illegal  = illegal_reg;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=16; flags are compared as {zero,carry,overflow,negative,illegal}.
module tb_alu_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  op;
   logic [15:0] a, b;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] result;
   logic        zero, carry, overflow, negative, illegal;
   logic [4:0]  flags;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [3:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] res;
      logic [4:0]  fl;
   } vec_t;

   assign flags = {zero, carry, overflow, negative, illegal};

   alu_seq #(.WIDTH(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .zero      (zero),
      .carry     (carry),
      .overflow  (overflow),
      .negative  (negative),
      .illegal   (illegal)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y);
      in_valid = 1'b1;
      op = o;
      a  = x;
      b  = y;
      step();
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op = 4'h0; a = '0; b = '0;
      step();
      step();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_hs in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
      end
      checks++;
      if (result !== 16'h0000 || flags !== 5'b00000) begin
         errors++;
         $display("FAIL reset_regs result=%h flags=%b expected 0000/00000", result, flags);
      end
      rst = 1'b0;
      step();
      $display("reset released in_ready=%b out_valid=%b", in_ready, out_valid);
   endtask

   task automatic test_add_sub();
      vec_t v[2];
      v[0] = '{op: 4'h0, a: 16'h7FFF, b: 16'h0001, res: 16'h8000, fl: 5'b00110};
      v[1] = '{op: 4'h1, a: 16'h0003, b: 16'h0005, res: 16'hFFFE, fl: 5'b01010};
      for (int i = 0; i < 2; i++) begin
         issue(v[i].op, v[i].a, v[i].b);
         $display("op=%h a=%h b=%h result=%h flags=%b", v[i].op, v[i].a, v[i].b, result, flags);
         checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL arith_latency[%0d] out_valid=%b in_ready=%b expected 1/0", i, out_valid, in_ready);
         end
         checks++;
         if (result !== v[i].res || flags !== v[i].fl) begin
            errors++;
            $display("FAIL arith_value[%0d] result=%h flags=%b expected %h/%b", i, result, flags, v[i].res, v[i].fl);
         end
         step();
         checks++;
         if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL arith_ack[%0d] out_valid=%b in_ready=%b expected 0/1", i, out_valid, in_ready);
         end
      end
   endtask

   task automatic test_logic_shift();
      vec_t v[10];
      v[0] = '{op: 4'h2, a: 16'hF0F0, b: 16'h0FF0, res: 16'h00F0, fl: 5'b00000};
      v[1] = '{op: 4'h3, a: 16'h0000, b: 16'h1234, res: 16'hFFFF, fl: 5'b00010};
      v[2] = '{op: 4'h4, a: 16'h0F00, b: 16'h00F0, res: 16'h0FF0, fl: 5'b00000};
      v[3] = '{op: 4'h5, a: 16'hAAAA, b: 16'hAAAA, res: 16'h0000, fl: 5'b10000};
      v[4] = '{op: 4'h7, a: 16'h8001, b: 16'h0011, res: 16'h4000, fl: 5'b01000};
      v[5] = '{op: 4'h6, a: 16'h8001, b: 16'h0001, res: 16'h0002, fl: 5'b01000};
      v[6] = '{op: 4'h6, a: 16'h1234, b: 16'h0010, res: 16'h1234, fl: 5'b00000};
      v[7] = '{op: 4'h8, a: 16'h8008, b: 16'h0004, res: 16'hF800, fl: 5'b01010};
      v[8] = '{op: 4'hF, a: 16'hFFFF, b: 16'hFFFF, res: 16'h0000, fl: 5'b10001};
      v[9] = '{op: 4'hA, a: 16'h0001, b: 16'h0001, res: 16'h0000, fl: 5'b10001};
      for (int i = 0; i < 10; i++) begin
         issue(v[i].op, v[i].a, v[i].b);
         $display("op=%h a=%h b=%h result=%h flags=%b", v[i].op, v[i].a, v[i].b, result, flags);
         checks++;
         if (out_valid !== 1'b1 || result !== v[i].res || flags !== v[i].fl) begin
            errors++;
            $display("FAIL logic_shift[%0d] out_valid=%b result=%h flags=%b expected 1/%h/%b",
                     i, out_valid, result, flags, v[i].res, v[i].fl);
         end
         step();
      end
   endtask

   task automatic test_mul();
      vec_t v[2];
      bit   early;
      v[0] = '{op: 4'h9, a: 16'h0100, b: 16'h0100, res: 16'h0000, fl: 5'b11100};
      v[1] = '{op: 4'h9, a: 16'h0003, b: 16'h0005, res: 16'h000F, fl: 5'b00000};
      for (int i = 0; i < 2; i++) begin
         issue(v[i].op, v[i].a, v[i].b);
         early = 1'b0;
         for (int c = 0; c < 16; c++) begin
            if (c > 0) step();
            if (out_valid !== 1'b0 || in_ready !== 1'b0) early = 1'b1;
         end
         checks++;
         if (early) begin
            errors++;
            $display("FAIL mul_busy[%0d] handshake not held during 15 busy cycles out_valid=%b in_ready=%b expected 0/0",
                     i, out_valid, in_ready);
         end
         step();
         $display("op=%h a=%h b=%h result=%h flags=%b", v[i].op, v[i].a, v[i].b, result, flags);
         checks++;
         if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL mul_latency[%0d] out_valid=%b 16 cycles after accept expected 1", i, out_valid);
         end
         checks++;
         if (result !== v[i].res || flags !== v[i].fl) begin
            errors++;
            $display("FAIL mul_value[%0d] result=%h flags=%b expected %h/%b", i, result, flags, v[i].res, v[i].fl);
         end
         step();
      end
   endtask

   task automatic test_stall();
      bit bad;
      out_ready = 1'b0;
      issue(4'h0, 16'h0001, 16'h0001);
      // Try to sneak a different op in while the result is held
      in_valid = 1'b1; op = 4'h5; a = 16'hFFFF; b = 16'h0000;
      bad = 1'b0;
      for (int c = 0; c < 5; c++) begin
         if (c > 0) step();
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 16'h0002 || flags !== 5'b00000) bad = 1'b1;
      end
      in_valid = 1'b0;
      $display("stall ADD 0001+0001 result=%h flags=%b out_valid=%b", result, flags, out_valid);
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL stall_hold result=%h out_valid=%b in_ready=%b expected 0002/1/0", result, out_valid, in_ready);
      end
      out_ready = 1'b1;
      step();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 16'h0002) begin
         errors++;
         $display("FAIL stall_release out_valid=%b in_ready=%b result=%h expected 0/1/0002", out_valid, in_ready, result);
      end
   endtask

   task automatic test_reset_mid_mul();
      bit stray;
      issue(4'h9, 16'h0100, 16'h0100);
      for (int c = 0; c < 7; c++) step();
      rst = 1'b1;
      #1;
      $display("rst during MUL iteration 7 out_valid=%b in_ready=%b", out_valid, in_ready);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL rst_abort out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
      end
      #1;
      rst = 1'b0;
      stray = 1'b0;
      for (int c = 0; c < 20; c++) begin
         step();
         if (out_valid !== 1'b0 || in_ready !== 1'b1) stray = 1'b1;
      end
      checks++;
      if (stray) begin
         errors++;
         $display("FAIL rst_no_partial out_valid=%b in_ready=%b expected 0/1 after abort", out_valid, in_ready);
      end
      issue(4'h2, 16'hF0F0, 16'h0FF0);
      $display("op=2 a=F0F0 b=0FF0 result=%h flags=%b", result, flags);
      checks++;
      if (out_valid !== 1'b1 || result !== 16'h00F0 || flags !== 5'b00000) begin
         errors++;
         $display("FAIL rst_then_and out_valid=%b result=%h flags=%b expected 1/00F0/00000", out_valid, result, flags);
      end
      step();
   endtask

   task automatic test_back_to_back();
      issue(4'h5, 16'hA5A5, 16'hFFFF);
      checks++;
      if (result !== 16'h5A5A || flags !== 5'b00000) begin
         errors++;
         $display("FAIL b2b_first result=%h flags=%b expected 5A5A/00000", result, flags);
      end
      // Next op presented during the handshake cycle must wait one cycle
      in_valid = 1'b1; op = 4'h0; a = 16'h0001; b = 16'h0002;
      step();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL b2b_gap out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
      end
      step();
      in_valid = 1'b0;
      $display("op=0 a=0001 b=0002 result=%h flags=%b", result, flags);
      checks++;
      if (out_valid !== 1'b1 || result !== 16'h0003 || flags !== 5'b00000) begin
         errors++;
         $display("FAIL b2b_second out_valid=%b result=%h flags=%b expected 1/0003/00000", out_valid, result, flags);
      end
      step();
   endtask

   initial begin
      test_reset();
      test_add_sub();
      test_logic_shift();
      test_mul();
      test_stall();
      test_reset_mid_mul();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
